// File: rtl/change_dispenser.sv
// change_dispenser: pays out 0-35 cents of change as dimes and nickels by
// handshaking with a coin hopper. Dimes are preferred while at least two
// nickels are owed. A stalled hopper (no hop_ack within ACK_TIMEOUT cycles)
// or, with inventory tracking, a coin shortfall latches a sticky fault.
//
// Build option: define CHANGE_INVENTORY_EN to add per-coin inventory
// counters, the refill input and the shortfall fault. Without it the hopper
// is assumed never to run dry and refill is ignored.
module change_dispenser #(
  parameter int INV_W       = 6,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       change_valid,
  input  logic [2:0] change,
  output logic       change_ready,
  output logic       hop_nickel,
  output logic       hop_dime,
  input  logic       hop_ack,
  input  logic       refill,
  output logic       done,
  output logic       fault,
  output logic [2:0] remaining
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_REQ      = 3'd1;
  localparam logic [2:0] S_WAIT_REL = 3'd2;
  localparam logic [2:0] S_DONE     = 3'd3;
  localparam logic [2:0] S_FAULT    = 3'd4;

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic [2:0]       state_q, state_d;
  logic [2:0]       remaining_q, remaining_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // lock_q: coin choice for the current request has been frozen in sel_dime_q
  logic             lock_q, lock_d;
  logic             sel_dime_q, sel_dime_d;

  logic dime_avail, nickel_avail;
  logic want_dime, want_nickel;
  logic coin_taken;

`ifdef CHANGE_INVENTORY_EN
  logic [INV_W-1:0] dime_inv_q, dime_inv_d;
  logic [INV_W-1:0] nickel_inv_q, nickel_inv_d;

  function automatic logic [INV_W-1:0] sat_dec(input logic [INV_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  assign dime_avail   = (dime_inv_q != '0);
  assign nickel_avail = (nickel_inv_q != '0);

  // Inventory update: refill reloads both counters and overrides a same-edge decrement
  always_comb begin
    dime_inv_d   = dime_inv_q;
    nickel_inv_d = nickel_inv_q;
    if (refill) begin
      dime_inv_d   = '1;
      nickel_inv_d = '1;
    end else if (coin_taken) begin
      if (hop_dime) dime_inv_d   = sat_dec(dime_inv_q);
      else          nickel_inv_d = sat_dec(nickel_inv_q);
    end
  end

  // Inventory registers, full after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dime_inv_q   <= '1;
      nickel_inv_q <= '1;
    end else begin
      dime_inv_q   <= dime_inv_d;
      nickel_inv_q <= nickel_inv_d;
    end
  end
`else
  logic [INV_W-1:0] unused_inv;
  assign unused_inv   = {INV_W{refill}};
  assign dime_avail   = 1'b1;
  assign nickel_avail = 1'b1;
`endif

  // Coin selection: fresh choice on the first REQ cycle, frozen choice afterwards
  always_comb begin
    want_dime   = (remaining_q >= 3'd2) && dime_avail;
    want_nickel = !want_dime && (remaining_q >= 3'd1) && nickel_avail;
    hop_dime    = 1'b0;
    hop_nickel  = 1'b0;
    if (state_q == S_REQ) begin
      hop_dime   = lock_q ? sel_dime_q  : want_dime;
      hop_nickel = lock_q ? !sel_dime_q : want_nickel;
    end
  end

  assign coin_taken   = (state_q == S_REQ) && hop_ack && (hop_dime || hop_nickel);
  assign change_ready = (state_q == S_IDLE);
  assign done         = (state_q == S_DONE);
  assign fault        = (state_q == S_FAULT);
  assign remaining    = remaining_q;

  // Payout FSM next-state, remaining balance and ack timeout counter
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cnt_d       = '0;
    lock_d      = 1'b0;
    sel_dime_d  = sel_dime_q;
    case (state_q)
      S_IDLE: begin
        if (change_valid) begin
          remaining_d = change;
          state_d     = (change == 3'd0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (!lock_q && !want_dime && !want_nickel) begin
          state_d = S_FAULT;
        end else if (coin_taken) begin
          remaining_d = remaining_q - (hop_dime ? 3'd2 : 3'd1);
          state_d     = S_WAIT_REL;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          state_d = S_FAULT;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          lock_d     = 1'b1;
          sel_dime_d = hop_dime;
        end
      end
      S_WAIT_REL: begin
        if (!hop_ack) state_d = (remaining_q != 3'd0) ? S_REQ : S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= 3'd0;
      cnt_q       <= '0;
      lock_q      <= 1'b0;
      sel_dime_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cnt_q       <= cnt_d;
      lock_q      <= lock_d;
      sel_dime_q  <= sel_dime_d;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed testbench for change_dispenser (default parameters). Inventory
// scenarios are included only when CHANGE_INVENTORY_EN is defined.
module tb_change_dispenser;

  logic       clk;
  logic       rst_n;
  logic       change_valid;
  logic [2:0] change;
  logic       change_ready;
  logic       hop_nickel;
  logic       hop_dime;
  logic       hop_ack;
  logic       refill;
  logic       done;
  logic       fault;
  logic [2:0] remaining;

  int n_total;
  int n_fail;

  change_dispenser dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .change_valid (change_valid),
    .change       (change),
    .change_ready (change_ready),
    .hop_nickel   (hop_nickel),
    .hop_dime     (hop_dime),
    .hop_ack      (hop_ack),
    .refill       (refill),
    .done         (done),
    .fault        (fault),
    .remaining    (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},  {31'd0, change_ready}, 32'd1);
    chk({tag, "_hopn"},   {31'd0, hop_nickel},   32'd0);
    chk({tag, "_hopd"},   {31'd0, hop_dime},     32'd0);
    chk({tag, "_done"},   {31'd0, done},         32'd0);
    chk({tag, "_fault"},  {31'd0, fault},        32'd0);
    chk({tag, "_rem"},    {29'd0, remaining},    32'd0);
  endtask

  // Called with the DUT in REQ: optional idle cycles, then one ack handshake.
  task automatic do_coin(input string tag, input bit dime, input int delay,
                         input logic [2:0] rem_after);
    chk({tag, "_hopd"}, {31'd0, hop_dime},   {31'd0, dime});
    chk({tag, "_hopn"}, {31'd0, hop_nickel}, {31'd0, !dime});
    for (int i = 0; i < delay; i++) begin
      tick();
      chk({tag, "_hold"}, {31'd0, hop_dime}, {31'd0, dime});
    end
    hop_ack = 1'b1;
    tick();
    chk({tag, "_drop"}, {30'd0, hop_dime, hop_nickel}, 32'd0);
    chk({tag, "_rem"},  {29'd0, remaining}, {29'd0, rem_after});
    hop_ack = 1'b0;
    tick();
  endtask

  task automatic offer(input logic [2:0] amt);
    change_valid = 1'b1;
    change       = amt;
    tick();
    change_valid = 1'b0;
    change       = 3'd0;
  endtask

  initial begin
    n_total      = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    change_valid = 1'b0;
    change       = 3'd0;
    hop_ack      = 1'b0;
    refill       = 1'b0;

    #12;
    chk_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // change=3: dime then nickel, ack two cycles after each request
    offer(3'd3);
    chk("p3_ready", {31'd0, change_ready}, 32'd0);
    chk("p3_rem0",  {29'd0, remaining},    32'd3);
    do_coin("p3_dime", 1'b1, 1, 3'd1);
    do_coin("p3_nick", 1'b0, 1, 3'd0);
    chk("p3_done", {31'd0, done}, 32'd1);
`ifdef CHANGE_INVENTORY_EN
    chk("p3_dinv", {26'd0, dut.dime_inv_q},   32'd62);
    chk("p3_ninv", {26'd0, dut.nickel_inv_q}, 32'd62);
`endif
    tick();
    chk("p3_done_1cyc", {31'd0, done},         32'd0);
    chk("p3_ready_back", {31'd0, change_ready}, 32'd1);

    // hop_ack while idle is ignored
    hop_ack = 1'b1;
    tick();
    chk("idle_ack_ready", {31'd0, change_ready}, 32'd1);
    chk("idle_ack_hop",   {30'd0, hop_dime, hop_nickel}, 32'd0);
    hop_ack = 1'b0;

    // change=0: straight to a single done pulse
    offer(3'd0);
    chk("z_done",  {31'd0, done}, 32'd1);
    chk("z_hop",   {30'd0, hop_dime, hop_nickel}, 32'd0);
    chk("z_ready", {31'd0, change_ready}, 32'd0);
    tick();
    chk("z_done_off", {31'd0, done},         32'd0);
    chk("z_ready_on", {31'd0, change_ready}, 32'd1);

    // change=5 with hopper silent: fault exactly 15 cycles after hop_dime rose
    offer(3'd5);
    chk("to_hopd_rise", {31'd0, hop_dime}, 32'd1);
    for (int i = 1; i < 15; i++) begin
      tick();
      chk("to_wait_fault", {31'd0, fault},    32'd0);
      chk("to_wait_hopd",  {31'd0, hop_dime}, 32'd1);
    end
    tick();
    chk("to_fault", {31'd0, fault},        32'd1);
    chk("to_hop",   {30'd0, hop_dime, hop_nickel}, 32'd0);
    chk("to_ready", {31'd0, change_ready}, 32'd0);
    chk("to_done",  {31'd0, done},         32'd0);
    change_valid = 1'b1;
    change       = 3'd2;
    hop_ack      = 1'b1;
    tick();
    chk("to_sticky", {31'd0, fault},        32'd1);
    chk("to_noacc",  {31'd0, change_ready}, 32'd0);
    change_valid = 1'b0;
    hop_ack      = 1'b0;
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("to_rst");
    #2;
    rst_n = 1'b1;
    tick();

    // change=7 interrupted by reset in WAIT_REL, then a clean payout
    offer(3'd7);
    chk("r7_hopd", {31'd0, hop_dime}, 32'd1);
    hop_ack = 1'b1;
    tick();
    chk("r7_rem5", {29'd0, remaining}, 32'd5);
    tick();
    chk("r7_wait_stay", {30'd0, hop_dime, hop_nickel}, 32'd0);
    chk("r7_wait_rem",  {29'd0, remaining}, 32'd5);
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("r7_rst");
`ifdef CHANGE_INVENTORY_EN
    chk("r7_dinv", {26'd0, dut.dime_inv_q},   32'd63);
    chk("r7_ninv", {26'd0, dut.nickel_inv_q}, 32'd63);
`endif
    hop_ack = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    offer(3'd7);
    do_coin("n7_d1", 1'b1, 0, 3'd5);
    do_coin("n7_d2", 1'b1, 0, 3'd3);
    do_coin("n7_d3", 1'b1, 0, 3'd1);
    do_coin("n7_n1", 1'b0, 0, 3'd0);
    chk("n7_done", {31'd0, done}, 32'd1);
    tick();
    chk("n7_ready", {31'd0, change_ready}, 32'd1);

`ifdef CHANGE_INVENTORY_EN
    // refill on the same edge as a nickel decrement: refill wins
    offer(3'd1);
    chk("rf_hopn", {31'd0, hop_nickel}, 32'd1);
    hop_ack = 1'b1;
    refill  = 1'b1;
    tick();
    refill  = 1'b0;
    hop_ack = 1'b0;
    chk("rf_ninv", {26'd0, dut.nickel_inv_q}, 32'd63);
    chk("rf_dinv", {26'd0, dut.dime_inv_q},   32'd63);
    tick();
    chk("rf_done", {31'd0, done}, 32'd1);
    tick();

    // drain all 63 dimes
    for (int i = 0; i < 63; i++) begin
      offer(3'd2);
      do_coin("dr_dime", 1'b1, 0, 3'd0);
      chk("dr_done", {31'd0, done}, 32'd1);
      tick();
    end
    chk("dr_dinv", {26'd0, dut.dime_inv_q}, 32'd0);

    // no dimes: change=4 is paid as four nickels
    offer(3'd4);
    do_coin("c4_n1", 1'b0, 0, 3'd3);
    do_coin("c4_n2", 1'b0, 0, 3'd2);
    do_coin("c4_n3", 1'b0, 0, 3'd1);
    do_coin("c4_n4", 1'b0, 0, 3'd0);
    chk("c4_done", {31'd0, done}, 32'd1);
    chk("c4_ninv", {26'd0, dut.nickel_inv_q}, 32'd59);
    tick();

    // drain remaining 59 nickels
    for (int i = 0; i < 59; i++) begin
      offer(3'd1);
      do_coin("dn_nick", 1'b0, 0, 3'd0);
      chk("dn_done", {31'd0, done}, 32'd1);
      tick();
    end
    chk("dn_ninv", {26'd0, dut.nickel_inv_q}, 32'd0);

    // change=7 with empty hopper: shortfall fault
    offer(3'd7);
    chk("sf_hop", {30'd0, hop_dime, hop_nickel}, 32'd0);
    tick();
    chk("sf_fault", {31'd0, fault},        32'd1);
    chk("sf_ready", {31'd0, change_ready}, 32'd0);
    tick();
    chk("sf_ready_stays", {31'd0, change_ready}, 32'd0);
    chk("sf_dinv_sat",    {26'd0, dut.dime_inv_q}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter INV_W, default 6: width of each coin inventory counter.
REQ-002 Parameter ACK_TIMEOUT, default 15: cycles a hopper request may wait for hop_ack before fault.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 change_valid  input  1  change amount offered by the vending machine.
REQ-006 change  input  3  change owed, in nickels (0-7, i.e. 0-35 cents).
REQ-007 change_ready  output  1  dispenser can accept a new amount.
REQ-008 hop_nickel  output  1  request hopper to eject one nickel; held until acknowledged.
REQ-009 hop_dime  output  1  request hopper to eject one dime; held until acknowledged.
REQ-010 hop_ack  input  1  hopper ejected the requested coin; level, held until request drops.
REQ-011 refill  input  1  one-cycle pulse: both inventories reload to full.
REQ-012 done  output  1  one-cycle pulse: payout complete.
REQ-013 fault  output  1  sticky: timeout or coin shortfall.
REQ-014 remaining  output  3  nickels still owed for the current payout.

Function
REQ-015 States SHALL be IDLE, REQ, WAIT_REL, DONE, FAULT; change_ready SHALL be 1 only in IDLE.
REQ-016 Transfer occurs when change_valid and change_ready are both high at a rising edge: remaining <= change, IDLE->REQ, or IDLE->DONE if change==0.
REQ-017 In REQ: if remaining>=2 and dime inventory>0, assert hop_dime; else if remaining>=1 and nickel inventory>0, assert hop_nickel; else go to FAULT (shortfall).
REQ-018 The first hop request SHALL appear the cycle after the transfer edge; at most one of hop_nickel/hop_dime is high; the selected coin SHALL NOT change until acknowledged.
REQ-019 hop_ack high in REQ: next edge drops the request, subtracts 2 (dime) or 1 (nickel) from remaining, decrements that inventory by 1, enters WAIT_REL.
REQ-020 WAIT_REL: stay while hop_ack high; when low, go to REQ if remaining>0, else DONE.
REQ-021 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-022 A cycle counter SHALL run while in REQ and clear on leaving REQ; reaching ACK_TIMEOUT without hop_ack SHALL enter FAULT.
REQ-023 FAULT: fault=1, hop_* = 0, change_ready=0, done=0; exit only via rst_n.
REQ-024 hop_ack outside REQ/WAIT_REL SHALL be ignored.
REQ-025 refill on the same edge as an inventory decrement: refill wins (counter = full).
REQ-026 Inventory counters SHALL saturate at 0 and never wrap.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, change_ready=1, hop_nickel=0, hop_dime=0, done=0, fault=0, remaining=0, timeout counter=0, both inventories = 2^INV_W-1, including mid-payout.

Configuration
REQ-028 Macro CHANGE_INVENTORY_EN defined: inventory counters, refill and shortfall fault (REQ-017, REQ-025, REQ-026) SHALL be implemented.
REQ-029 CHANGE_INVENTORY_EN undefined: inventories SHALL be treated as always non-empty, refill SHALL be ignored, and only timeout may raise fault.

Verification
REQ-030 change=3, full inventory, hop_ack 2 cycles after each request -> hop_dime, then hop_nickel, remaining 3->1->0, one done pulse, dime and nickel inventory each -1.
REQ-031 change=0 accepted -> done high the following cycle, no hop_* activity, back to change_ready=1.
REQ-032 Macro defined, dime inventory drained to 0, change=4 -> four hop_nickel handshakes, done; then change=7 with nickels drained -> fault, change_ready stays 0.
REQ-033 change=5, hop_ack held low -> fault asserts exactly ACK_TIMEOUT cycles after the hop_dime request rose, hop_dime drops.
REQ-034 rst_n pulsed low during WAIT_REL of a change=7 payout -> all outputs at reset values asynchronously, inventories full, next payout proceeds normally.
REQ-035 refill on the same edge as a hop_ack-driven decrement -> that inventory reads 2^INV_W-1 afterwards.
